// File: rtl/store_buffer_fwd_if.sv
// Bus bundle for the MEM-stage store buffer: store push, load lookup,
// dcache write drain and occupancy status.
interface store_buffer_fwd_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [BE_W-1:0]   st_be;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [BE_W-1:0]   ld_be;
    logic [DATA_W-1:0] ld_fwd_data;
    logic [BE_W-1:0]   ld_fwd_be;
    logic              ld_fwd_hit;
    logic              ld_stall;

    logic              cache_wr_valid;
    logic              cache_wr_ready;
    logic [ADDR_W-1:0] cache_wr_addr;
    logic [DATA_W-1:0] cache_wr_data;
    logic [BE_W-1:0]   cache_wr_be;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output st_valid, st_addr, st_data, st_be,
        output ld_valid, ld_addr, ld_be,
        output cache_wr_ready,
        input  st_ready,
        input  ld_fwd_data, ld_fwd_be, ld_fwd_hit, ld_stall,
        input  cache_wr_valid, cache_wr_addr, cache_wr_data, cache_wr_be,
        input  count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be,
        input  ld_valid, ld_addr, ld_be,
        input  cache_wr_ready,
        output st_ready,
        output ld_fwd_data, ld_fwd_be, ld_fwd_hit, ld_stall,
        output cache_wr_valid, cache_wr_addr, cache_wr_data, cache_wr_be,
        output count, empty, full
    );
endinterface

// File: rtl/store_buffer_fwd.sv
// FIFO store buffer: drains committed stores oldest-first to the dcache and
// forwards buffered bytes to younger loads, stalling on partial overlap.
module store_buffer_fwd #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic               clock,
    input logic               reset,
    store_buffer_fwd_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - OFF_W;

    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [BE_W-1:0]   mem_be   [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              full_q;
    logic              empty_q;
    logic              push;
    logic              pop;

    logic [PTR_W-1:0]  idx;
    logic [BE_W-1:0]   match_be;
    logic [DATA_W-1:0] merge_data;
    logic [BE_W-1:0]   fwd_be;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_hit;
    logic              unused_addr_bits;

    assign empty_q = (count_q == '0);
    assign full_q  = (count_q == CNT_W'(DEPTH));
    assign push    = bus.st_valid && !full_q;
    assign pop     = !empty_q && bus.cache_wr_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // Occupancy is derived from head/count, so the array itself needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_tag[tail]  <= bus.st_addr[ADDR_W-1:OFF_W];
            mem_data[tail] <= bus.st_data;
            mem_be[tail]   <= bus.st_be;
        end
    end

    // Walk oldest to youngest so a later matching entry overwrites each lane.
    always_comb begin
        idx        = head;
        match_be   = '0;
        merge_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (mem_tag[idx] == bus.ld_addr[ADDR_W-1:OFF_W])) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (mem_be[idx][b]) begin
                        match_be[b]          = 1'b1;
                        merge_data[8*b +: 8] = mem_data[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_be   = '0;
        fwd_data = '0;
        if (bus.ld_valid) begin
            fwd_be = match_be & bus.ld_be;
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (fwd_be[b]) fwd_data[8*b +: 8] = merge_data[8*b +: 8];
            end
        end
    end

    assign fwd_hit          = bus.ld_valid && (fwd_be == bus.ld_be) && (bus.ld_be != '0);

    assign bus.ld_fwd_be    = fwd_be;
    assign bus.ld_fwd_data  = fwd_data;
    assign bus.ld_fwd_hit   = fwd_hit;
    assign bus.ld_stall     = (fwd_be != '0) && !fwd_hit;

    assign bus.st_ready       = !full_q;
    assign bus.cache_wr_valid = !empty_q;
    assign bus.cache_wr_addr  = {mem_tag[head], {OFF_W{1'b0}}};
    assign bus.cache_wr_data  = mem_data[head];
    assign bus.cache_wr_be    = mem_be[head];

    assign bus.count = count_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;

    assign unused_addr_bits = &{1'b0, bus.st_addr[OFF_W-1:0], bus.ld_addr[OFF_W-1:0]};
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Self-checking bench for store_buffer_fwd: drain scoreboard plus directed
// forwarding, full, wrap and asynchronous-reset scenarios.
module tb_store_buffer_fwd;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        be;
    } wr_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   model_count = 0;
    wr_t  exp_q [$];

    always #5 clock = ~clock;

    store_buffer_fwd_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    store_buffer_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Called at a falling edge with inputs driven; advances to the next falling edge.
    task automatic tick();
        wr_t e;
        wr_t got;
        #1;
        if (bus.cache_wr_valid && bus.cache_wr_ready) begin
            checks++;
            got = '{bus.cache_wr_addr, bus.cache_wr_data, bus.cache_wr_be};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL drain_unexpected got=%h expected no write", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL drain_order got=%h expected=%h", got, e);
                end
            end
        end
        checks++;
        if (bus.st_ready !== (model_count != DEPTH)) begin
            failures++;
            $display("FAIL st_ready got=%b expected=%b", bus.st_ready, model_count != DEPTH);
        end
        if (bus.st_valid && model_count != DEPTH)
            exp_q.push_back('{bus.st_addr & ~32'h3, bus.st_data, bus.st_be});
        model_count = model_count + ((bus.st_valid && model_count != DEPTH) ? 1 : 0)
                                  - ((bus.cache_wr_ready && model_count != 0) ? 1 : 0);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.count !== 3'(model_count)) begin
            failures++;
            $display("FAIL count got=%0d expected=%0d", bus.count, model_count);
        end
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_be    = be;
    endtask

    task automatic test_reset();
        reset              = 1'b0;
        bus.st_valid       = 1'b0;
        bus.st_addr        = '0;
        bus.st_data        = '0;
        bus.st_be          = '0;
        bus.ld_valid       = 1'b1;
        bus.ld_addr        = '0;
        bus.ld_be          = 4'hF;
        bus.cache_wr_ready = 1'b0;
        #1;
        checks++;
        if ({bus.empty, bus.full, bus.st_ready, bus.cache_wr_valid, bus.ld_fwd_hit,
             bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data, bus.count} !== {1'b1, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_outputs got e=%b f=%b r=%b v=%b h=%b s=%b be=%h d=%h c=%0d expected 1 0 1 0 0 0 0 0 0",
                     bus.empty, bus.full, bus.st_ready, bus.cache_wr_valid, bus.ld_fwd_hit,
                     bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data, bus.count);
        end
        bus.ld_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_single();
        drive_store(32'h4, 32'd10, 4'hF);
        tick();
        bus.st_valid = 1'b0;
        checks++;
        if ({bus.cache_wr_valid, bus.cache_wr_addr, bus.cache_wr_data, bus.cache_wr_be} !==
            {1'b1, 32'h4, 32'd10, 4'hF}) begin
            failures++;
            $display("FAIL single_head got v=%b a=%h d=%0d be=%h expected v=1 a=4 d=10 be=f",
                     bus.cache_wr_valid, bus.cache_wr_addr, bus.cache_wr_data, bus.cache_wr_be);
        end
        bus.cache_wr_ready = 1'b1;
        tick();
        bus.cache_wr_ready = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_empty got empty=%b valid=%b expected 1 0", bus.empty, bus.cache_wr_valid);
        end
    endtask

    task automatic test_full();
        logic [31:0] addrs [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] vals  [4] = '{32'd10, 32'd15, 32'd12, 32'd16};
        for (int i = 0; i < 4; i++) begin
            drive_store(addrs[i], vals[i], 4'hF);
            tick();
        end
        checks++;
        if (bus.full !== 1'b1 || bus.st_ready !== 1'b0 || bus.empty !== 1'b0) begin
            failures++;
            $display("FAIL full_flags got full=%b st_ready=%b empty=%b expected 1 0 0",
                     bus.full, bus.st_ready, bus.empty);
        end
        drive_store(32'h40, 32'd13, 4'hF);
        tick();
        // Full with a pop in the same cycle must still reject the store.
        bus.cache_wr_ready = 1'b1;
        tick();
        bus.st_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.cache_wr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL full_drain got pending=%0d empty=%b expected 0 1", exp_q.size(), bus.empty);
        end
    endtask

    task automatic test_forward();
        drive_store(32'h10, 32'd16, 4'hF);
        tick();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h10;
        bus.ld_be    = 4'hF;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b1, 1'b0, 4'hF, 32'd16}) begin
            failures++;
            $display("FAIL fwd_hit got h=%b s=%b be=%h d=%h expected 1 0 f 10",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.ld_addr = 32'h14;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b0, 1'b0, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL fwd_miss got h=%b s=%b be=%h d=%h expected 0 0 0 0",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.ld_addr  = 32'h10;
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b0, 1'b0, 4'h0, 32'h0}) begin
            failures++;
            $display("FAIL fwd_gated got h=%b s=%b be=%h d=%h expected 0 0 0 0",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.cache_wr_ready = 1'b1;
        tick();
        bus.cache_wr_ready = 1'b0;
    endtask

    task automatic test_merge();
        drive_store(32'h8, 32'h11223344, 4'hF);
        tick();
        drive_store(32'h8, 32'h000000AA, 4'h1);
        tick();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h8;
        bus.ld_be    = 4'hF;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b1, 1'b0, 4'hF, 32'h112233AA}) begin
            failures++;
            $display("FAIL merge_youngest got h=%b s=%b be=%h d=%h expected 1 0 f 112233aa",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.ld_be = 4'h2;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b1, 1'b0, 4'h2, 32'h00003300}) begin
            failures++;
            $display("FAIL merge_lane got h=%b s=%b be=%h d=%h expected 1 0 2 00003300",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.ld_be = 4'hF;
        bus.cache_wr_ready = 1'b1;
        tick();
        bus.cache_wr_ready = 1'b0;
        #1;
        checks++;
        if ({bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data} !== {1'b0, 1'b1, 4'h1, 32'h000000AA}) begin
            failures++;
            $display("FAIL partial_stall got h=%b s=%b be=%h d=%h expected 0 1 1 000000aa",
                     bus.ld_fwd_hit, bus.ld_stall, bus.ld_fwd_be, bus.ld_fwd_data);
        end
        bus.cache_wr_ready = 1'b1;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b1) begin
            failures++;
            $display("FAIL pop_visible got stall=%b expected 1", bus.ld_stall);
        end
        tick();
        bus.cache_wr_ready = 1'b0;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b0 || bus.ld_fwd_hit !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got stall=%b hit=%b expected 0 0", bus.ld_stall, bus.ld_fwd_hit);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF);
            tick();
        end
        bus.cache_wr_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            drive_store(32'h100 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)));
            tick();
        end
        bus.st_valid = 1'b0;
        tick();
        tick();
        bus.cache_wr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_drain got pending=%0d empty=%b expected 0 1", exp_q.size(), bus.empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h200 + 32'(4 * i), 32'hB000 + 32'(i), 4'hF);
            tick();
        end
        bus.st_valid = 1'b0;
        checks++;
        if (bus.count !== 3'd3 || bus.cache_wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got count=%0d valid=%b expected 3 1", bus.count, bus.cache_wr_valid);
        end
        bus.cache_wr_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.cache_wr_valid !== 1'b0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got count=%0d valid=%b empty=%b expected 0 0 1",
                     bus.count, bus.cache_wr_valid, bus.empty);
        end
        exp_q.delete();
        model_count = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.cache_wr_ready = 1'b0;
        checks++;
        if (bus.cache_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_write got valid=%b expected 0", bus.cache_wr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_merge();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
